// File: rtl/axi4_gen2_pkg.sv
// rtl/axi4_gen2_pkg.sv - shared burst, response and FSM state types for the gen2 AXI4 memory slave
package axi4_gen2_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'd0,
    INCR  = 2'd1,
    WRAP  = 2'd2,
    RSVD  = 2'd3
  } burst_t;

  typedef logic [1:0] resp_t;
  localparam resp_t OKAY   = 2'b00;
  localparam resp_t SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  // Wrapping bursts are only legal for 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi4_burst_addr.sv
// rtl/axi4_burst_addr.sv - next beat byte address for FIXED/INCR/WRAP bursts (WRAP only with AXI4_SLAVE_WRAP_EN)
module axi4_burst_addr
  import axi4_gen2_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] addr,
  input  burst_t            burst,
  input  logic [7:0]        len,
  output logic [ADDR_W-1:0] next_addr
);

  localparam int BYTES = DATA_W / 8;

  logic [ADDR_W-1:0] incr_addr;
  assign incr_addr = addr + ADDR_W'(BYTES);

`ifdef AXI4_SLAVE_WRAP_EN
  // The wrap window is (len+1) beats wide and aligned to its own size.
  logic [ADDR_W-1:0] wrap_mask;
  assign wrap_mask = ADDR_W'((int'(len) + 1) * BYTES - 1);
`else
  logic unused_len;
  assign unused_len = ^len;
`endif

  // Select the advance rule for the current burst type.
  always_comb begin
    next_addr = addr;
    case (burst)
      INCR:    next_addr = incr_addr;
`ifdef AXI4_SLAVE_WRAP_EN
      WRAP:    next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
`endif
      default: next_addr = addr;
    endcase
  end

endmodule

// File: rtl/axi4_slave_gen2.sv
// rtl/axi4_slave_gen2.sv - AXI4 burst memory slave, independent read/write FSMs, optional WRAP via AXI4_SLAVE_WRAP_EN
module axi4_slave_gen2
  import axi4_gen2_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 1024
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic [7:0]          AWLEN,
  input  logic [1:0]          AWBURST,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                WLAST,
  input  logic                WVALID,
  output logic                WREADY,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  input  logic [ADDR_W-1:0]   ARADDR,
  input  logic [7:0]          ARLEN,
  input  logic [1:0]          ARBURST,
  input  logic                ARVALID,
  output logic                ARREADY,
  output logic [DATA_W-1:0]   RDATA,
  output logic [1:0]          RRESP,
  output logic                RLAST,
  output logic                RVALID,
  input  logic                RREADY
);

  localparam int BYTES = DATA_W / 8;
  localparam int SHIFT = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(DEPTH);

  // A beat errs when it falls past the memory or its burst type is unusable.
  function automatic logic beat_bad(input logic [ADDR_W-1:0] addr, input burst_t burst,
                                    input logic [7:0] len);
    logic bad;
    bad = ({1'b0, addr >> SHIFT} >= DEPTH_A);
    case (burst)
      RSVD: bad = 1'b1;
`ifdef AXI4_SLAVE_WRAP_EN
      WRAP: if (!wrap_len_ok(len)) bad = 1'b1;
`else
      WRAP: bad = 1'b1;
`endif
      default: ;
    endcase
    return bad;
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  // ---------------- write path ----------------
  wstate_t           wstate;
  logic [ADDR_W-1:0] waddr, waddr_next;
  burst_t            wburst;
  logic [7:0]        wlen, wcnt;
  logic              werr, w_bad, w_fire, w_last_beat;
  resp_t             bresp_q;

  axi4_burst_addr #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_waddr (
    .addr(waddr), .burst(wburst), .len(wlen), .next_addr(waddr_next)
  );

  assign w_bad       = beat_bad(waddr, wburst, wlen);
  assign w_last_beat = (wcnt == wlen);
  assign w_fire      = !ARESET && (wstate == W_DATA) && WVALID;

  // Write FSM: accept address, count beats, collect errors, hold response until taken.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wstate  <= W_IDLE;
      waddr   <= '0;
      wburst  <= FIXED;
      wlen    <= '0;
      wcnt    <= '0;
      werr    <= 1'b0;
      bresp_q <= OKAY;
    end else begin
      case (wstate)
        W_IDLE: if (AWVALID) begin
          waddr  <= AWADDR;
          wburst <= burst_t'(AWBURST);
          wlen   <= AWLEN;
          wcnt   <= '0;
          werr   <= 1'b0;
          wstate <= W_DATA;
        end
        W_DATA: if (WVALID) begin
          if (w_last_beat) begin
            bresp_q <= (werr || w_bad || !WLAST) ? SLVERR : OKAY;
            wstate  <= W_RESP;
          end else begin
            waddr <= waddr_next;
            wcnt  <= wcnt + 8'd1;
            werr  <= werr || w_bad || WLAST;
          end
        end
        W_RESP: if (BREADY) wstate <= W_IDLE;
        default: wstate <= W_IDLE;
      endcase
    end
  end

  // Byte-enabled memory write; erring beats leave memory untouched.
  always_ff @(posedge ACLK) begin
    if (w_fire && !w_bad) begin
      for (int b = 0; b < BYTES; b++) begin
        if (WSTRB[b]) mem[waddr[SHIFT +: IDX_W]][8*b +: 8] <= WDATA[8*b +: 8];
      end
    end
  end

  // ---------------- read path ----------------
  rstate_t           rstate;
  logic [ADDR_W-1:0] raddr, raddr_next, rf_addr;
  burst_t            rburst, rf_burst;
  logic [7:0]        rlen, rcnt, rf_len;
  logic              rf_bad, rlast_q;
  logic [DATA_W-1:0] rdata_q;
  resp_t             rresp_q;

  axi4_burst_addr #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_raddr (
    .addr(raddr), .burst(rburst), .len(rlen), .next_addr(raddr_next)
  );

  // Beat to fetch next: the AR request when idle, otherwise the following burst beat.
  always_comb begin
    rf_addr  = raddr_next;
    rf_burst = rburst;
    rf_len   = rlen;
    if (rstate == R_IDLE) begin
      rf_addr  = ARADDR;
      rf_burst = burst_t'(ARBURST);
      rf_len   = ARLEN;
    end
  end

  assign rf_bad = beat_bad(rf_addr, rf_burst, rf_len);

  // Read FSM: registered data per beat, held while the master stalls.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rstate  <= R_IDLE;
      raddr   <= '0;
      rburst  <= FIXED;
      rlen    <= '0;
      rcnt    <= '0;
      rlast_q <= 1'b0;
      rdata_q <= '0;
      rresp_q <= OKAY;
    end else begin
      case (rstate)
        R_IDLE: if (ARVALID) begin
          raddr   <= ARADDR;
          rburst  <= rf_burst;
          rlen    <= ARLEN;
          rcnt    <= '0;
          rlast_q <= (ARLEN == 8'd0);
          rdata_q <= rf_bad ? '0 : mem[rf_addr[SHIFT +: IDX_W]];
          rresp_q <= rf_bad ? SLVERR : OKAY;
          rstate  <= R_DATA;
        end
        R_DATA: if (RREADY) begin
          if (rlast_q) begin
            rstate <= R_IDLE;
          end else begin
            raddr   <= raddr_next;
            rcnt    <= rcnt + 8'd1;
            rlast_q <= ((rcnt + 8'd1) == rlen);
            rdata_q <= rf_bad ? '0 : mem[rf_addr[SHIFT +: IDX_W]];
            rresp_q <= rf_bad ? SLVERR : OKAY;
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  assign AWREADY = !ARESET && (wstate == W_IDLE);
  assign WREADY  = !ARESET && (wstate == W_DATA);
  assign BVALID  = !ARESET && (wstate == W_RESP);
  assign BRESP   = ARESET ? OKAY : bresp_q;
  assign ARREADY = !ARESET && (rstate == R_IDLE);
  assign RVALID  = !ARESET && (rstate == R_DATA);
  assign RDATA   = ARESET ? '0 : rdata_q;
  assign RRESP   = ARESET ? OKAY : rresp_q;
  assign RLAST   = RVALID && rlast_q;

endmodule
